// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle on magnitudes, followed by a single sign-fix cycle.
module mul_div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDUOp,
   input  logic        Start,
   input  logic        Flush,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] a_q, a_d;
   logic [31:0] opnd_q, opnd_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;

   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] add_sum;
   logic [32:0] div_shift;
   logic [32:0] sub_diff;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   // Unsigned ops have MDUOp[0]=1; magnitude of 0x80000000 is 2^31, which fits unsigned.
   assign a_neg = ~MDUOp[0] & A[31];
   assign b_neg = ~MDUOp[0] & B[31];
   assign a_mag = a_neg ? (~A + 32'd1) : A;
   assign b_mag = b_neg ? (~B + 32'd1) : B;

   // Multiply: accumulator upper half gathers partial sums while the multiplier shifts out.
   assign add_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
   // Divide: {remainder, dividend} shifts left; borrow-free subtract sets the quotient bit.
   assign div_shift = {acc_q[63:32], acc_q[31]};
   assign sub_diff  = div_shift - {1'b0, opnd_q};

   assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
   assign quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
   assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      a_d       = a_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         IDLE: begin
            if (Start && !Flush) begin
               case (MDUOp)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     is_div_d  = MDUOp[1];
                     neg_res_d = a_neg ^ b_neg;
                     neg_rem_d = a_neg;
                     a_d       = A;
                     cnt_d     = 5'd0;
                     state_d   = CALC;
                     if (MDUOp[1]) begin
                        acc_d  = {32'd0, a_mag};
                        opnd_d = b_mag;
                     end else begin
                        acc_d  = {32'd0, b_mag};
                        opnd_d = a_mag;
                     end
                  end
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         CALC: begin
            if (Flush) begin
               state_d = IDLE;
            end else begin
               if (is_div_q) begin
                  if (!sub_diff[32]) begin
                     acc_d = {sub_diff[31:0], acc_q[30:0], 1'b1};
                  end else begin
                     acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
                  end
               end else begin
                  acc_d = {add_sum, acc_q[31:1]};
               end
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_d = FIX;
               end
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!Flush) begin
               if (!is_div_q) begin
                  hi_d = prod_fix[63:32];
                  lo_d = prod_fix[31:0];
               end else if (opnd_q == 32'd0) begin
                  // Divide by zero reports the dividend untouched and an all-ones quotient.
                  hi_d = a_q;
                  lo_d = 32'hFFFF_FFFF;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 5'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         a_q       <= 32'd0;
         opnd_q    <= 32'd0;
         acc_q     <= 64'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         a_q       <= a_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
      end
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  32  operand 1: multiplicand or dividend, or the MTHI/MTLO source.
REQ-005 B  input  32  operand 2: multiplier or divisor.
REQ-006 MDUOp  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 SHALL be no-ops.
REQ-007 Start  input  1  request strobe, sampled only while idle.
REQ-008 Flush  input  1  abort (pipeline exception flush).
REQ-009 Busy  output  1  high while an iterative operation is in progress.
REQ-010 HI  output  32  HI register: product upper word or remainder.
REQ-011 LO  output  32  LO register: product lower word or quotient.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and FIX.
REQ-013 In IDLE, Start=1 with MUL/DIV ops SHALL latch A, B, the op and the operand signs, and SHALL enter CALC with iteration count 0.
REQ-014 Busy SHALL equal 1 exactly when state is CALC or FIX, as a registered state decode.
REQ-015 CALC SHALL perform one radix-2 step per cycle for 32 cycles: shift-add for multiply, restoring shift-subtract for divide.
REQ-016 CALC SHALL iterate on unsigned magnitudes; signed ops SHALL take the two's-complement magnitude of negative operands, and 0x80000000 SHALL map to magnitude 2^31.
REQ-017 After the 32nd CALC cycle the FSM SHALL enter FIX for one cycle, apply sign correction, and write HI/LO at the FIX->IDLE edge.
REQ-018 Latency: with Start sampled at edge k, Busy SHALL be 1 after edges k..k+32, and HI/LO SHALL hold new values and Busy=0 after edge k+33.
REQ-019 MULT/MULTU SHALL produce the 64-bit product as {HI,LO}; MULT SHALL negate the product when exactly one operand is negative.
REQ-020 DIV/DIVU SHALL write the quotient to LO and the remainder to HI.
REQ-021 DIV SHALL give the quotient sign A[31]^B[31] and the remainder sign A[31], truncating toward zero.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0, with no trap.
REQ-023 Divide by zero (B=0, DIV or DIVU) SHALL keep the full latency and SHALL yield HI=A and LO=0xFFFFFFFF.
REQ-024 MTHI/MTLO with Start=1 in IDLE SHALL write A to HI or LO at that edge; Busy SHALL stay 0 and the other register SHALL be unchanged.
REQ-025 Start while Busy=1 SHALL be ignored, with no queuing.
REQ-026 Start with MDUOp 110 or 111 SHALL change nothing.
REQ-027 Flush=1 in CALC or FIX SHALL return the FSM to IDLE at that edge, leaving HI/LO unchanged and Busy=0 after the edge.
REQ-028 Flush=1 in the FIX cycle SHALL suppress the HI/LO write.
REQ-029 Flush and Start both high in IDLE: Flush SHALL win, and no operation or MTHI/MTLO SHALL occur.
REQ-030 HI/LO SHALL be stable at all times except at the completion edge or an MTHI/MTLO edge.
REQ-031 The block SHALL never expose intermediate values on HI/LO.

Reset
REQ-032 rst=1 at an edge SHALL set state=IDLE, Busy=0, HI=0, LO=0 and clear the iteration count and latched operands.
REQ-033 rst SHALL dominate Start and Flush, including mid-operation; the aborted result SHALL be discarded.

Verification
REQ-034 MULT A=0xFFFFFFFE, B=0x00000003 -> Busy=1 for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; a Start during Busy must not alter the result.
REQ-036 DIV A=0xFFFFFFF9, B=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
REQ-037 DIVU A=0x00000064, B=0 -> after 33 Busy cycles HI=0x00000064, LO=0xFFFFFFFF.
REQ-038 Prior HI=0x11111111, LO=0x22222222; MULTU 5*7 with Flush at the 10th Busy cycle -> Busy=0 next cycle, HI/LO unchanged; a repeat without Flush -> HI=0, LO=0x00000023.
REQ-039 MTHI A=0x12345678 -> HI=0x12345678 after one edge, Busy never 1; rst asserted mid-DIV -> HI=LO=0 and Busy=0 after that edge.
